// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array sequencer:
//   - state_e      : sequencer FSM states, 3-bit encoding
//   - DEF_N, DEF_DATA_W, DEF_ACC_W : default array geometry
//   - drain_cycles : en-high cycles needed after the last activation
// ---------------------------------------------------------------------------
package systolic_pkg;

   localparam int DEF_N      = 8;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ACC_W  = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WLOAD  = 3'd1,
      CLEAR  = 3'd2,
      STREAM = 3'd3,
      DRAIN  = 3'd4,
      DONE   = 3'd5
   } state_e;

   // A partial sum needs N hops down and N hops across to leave the array.
   function automatic int drain_cycles(input int n);
      return 2 * n;
   endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl_if
// Bundles the data-plane signals of the sequencer:
//   wbuf_*  : weight buffer read port (data returns 1 cycle after rd_en)
//   act_*   : activation vector stream into the sequencer
//   sa_*    : systolic array control and data inputs
//   res_*   : result hand-off to the consumer
// Modports: master = sequencer side, slave = environment side.
//
// Handshake rule for act_* and res_*: a transfer happens in exactly the cycle
// where valid and ready are both high at the clock edge; the sender keeps
// valid (and data) stable until that cycle, and the receiver's ready may be
// asserted or withdrawn freely.
// ---------------------------------------------------------------------------
interface systolic_seq_ctrl_if #(
   parameter int N      = 8,
   parameter int DATA_W = 8
);
   localparam int AW = (N > 1) ? $clog2(N) : 1;

   logic                wbuf_rd_en;
   logic [AW-1:0]       wbuf_rd_addr;
   logic [N*DATA_W-1:0] wbuf_rd_data;

   logic                act_valid;
   logic                act_ready;
   logic [N*DATA_W-1:0] act_data;

   logic                sa_en;
   logic                sa_clear_acc;
   logic                sa_load_weight;
   logic [AW-1:0]       sa_load_row;
   logic [N*DATA_W-1:0] sa_weight_vector;
   logic [N*DATA_W-1:0] sa_act_vector;

   logic                res_valid;
   logic                res_ready;

   modport master (
      output wbuf_rd_en, wbuf_rd_addr,
      input  wbuf_rd_data,
      input  act_valid, act_data,
      output act_ready,
      output sa_en, sa_clear_acc, sa_load_weight, sa_load_row,
      output sa_weight_vector, sa_act_vector,
      output res_valid,
      input  res_ready
   );

   modport slave (
      input  wbuf_rd_en, wbuf_rd_addr,
      output wbuf_rd_data,
      output act_valid, act_data,
      input  act_ready,
      input  sa_en, sa_clear_acc, sa_load_weight, sa_load_row,
      input  sa_weight_vector, sa_act_vector,
      input  res_valid,
      output res_ready
   );

endinterface

// File: rtl/sysctrl_wload_seq.sv
// ---------------------------------------------------------------------------
// sysctrl_wload_seq
// Weight-load sequencer. While go_i is high it issues N buffer reads at
// addresses 0..N-1 and, one cycle behind each read, a load strobe with the
// matching row index. The pass takes N+1 cycles; done_o marks the last one.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   go_i       : high for the whole weight-load phase
//   rd_en_o    : buffer read strobe
//   rd_addr_o  : buffer row address (0 when not reading)
//   load_o     : array weight load strobe
//   row_o      : array target row (0 when not loading)
//   done_o     : final cycle of the pass
// ---------------------------------------------------------------------------
module sysctrl_wload_seq #(
   parameter int N  = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          go_i,
   output logic          rd_en_o,
   output logic [AW-1:0] rd_addr_o,
   output logic          load_o,
   output logic [AW-1:0] row_o,
   output logic          done_o
);
   // Counts 0..N: N read cycles plus one trailing cycle for the last load.
   localparam int CW = $clog2(N + 1);

   logic [CW-1:0] cyc_q, cyc_d;
   logic          load_q;
   logic [AW-1:0] row_q;

   assign rd_en_o   = go_i && (cyc_q < CW'(N));
   assign rd_addr_o = rd_en_o ? cyc_q[AW-1:0] : '0;
   assign done_o    = go_i && (cyc_q == CW'(N));
   assign load_o    = load_q;
   assign row_o     = row_q;

   always_comb begin
      cyc_d = '0;
      if (go_i && !done_o) cyc_d = cyc_q + CW'(1);
   end

   // Read data arrives one cycle after the strobe, so the load strobe and
   // row index are the read strobe and address delayed by one register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q  <= '0;
         load_q <= 1'b0;
         row_q  <= '0;
      end else begin
         cyc_q  <= cyc_d;
         load_q <= rd_en_o;
         row_q  <= rd_addr_o;
      end
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl
// Tile sequencer for an N x N weight-stationary systolic array. A start in
// IDLE runs one tile: weight load (skipped when cfg_reuse_w=1), one
// accumulator clear, cfg_num_vec activation vectors through a valid/ready
// handshake, DRAIN_CYC drain cycles, then res_valid held until res_ready.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a tile (sampled only in IDLE)
//   cfg_num_vec     : activation vectors in the tile
//   cfg_reuse_w     : keep resident weights, skip the weight load
//   busy            : high in every state except IDLE
//   dbg_state       : current FSM state (systolic_pkg::state_e encoding)
//   bus             : weight buffer, activation, array and result signals
// Optional build macro SYSCTRL_PERF_CNT_EN adds:
//   perf_clr        : synchronous clear of the performance counters
//   perf_busy_cyc   : saturating count of busy cycles
//   perf_stall_cyc  : saturating count of STREAM cycles without act_valid
// ---------------------------------------------------------------------------
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int CNT_W     = 16,
   parameter int DRAIN_CYC = drain_cycles(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] cfg_num_vec,
   input  logic             cfg_reuse_w,
   output logic             busy,
   output logic [2:0]       dbg_state,
   systolic_seq_ctrl_if.master bus
`ifdef SYSCTRL_PERF_CNT_EN
   ,
   input  logic             perf_clr,
   output logic [31:0]      perf_busy_cyc,
   output logic [31:0]      perf_stall_cyc
`endif
);
   localparam int AW = (N > 1) ? $clog2(N) : 1;
   localparam int DW = $clog2(DRAIN_CYC + 1);

   localparam logic [2:0] S_IDLE   = IDLE;
   localparam logic [2:0] S_WLOAD  = WLOAD;
   localparam logic [2:0] S_CLEAR  = CLEAR;
   localparam logic [2:0] S_STREAM = STREAM;
   localparam logic [2:0] S_DRAIN  = DRAIN;
   localparam logic [2:0] S_DONE   = DONE;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] num_vec_q, num_vec_d;
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [DW-1:0]    drain_q, drain_d;

   logic             act_fire;
   logic             wl_go, wl_rd_en, wl_load, wl_done;
   logic [AW-1:0]    wl_addr, wl_row;

   assign act_fire = (state_q == S_STREAM) && bus.act_valid;
   assign wl_go    = (state_q == S_WLOAD);

   sysctrl_wload_seq #(
      .N  (N),
      .AW (AW)
   ) u_wload (
      .clk       (clk),
      .rst       (rst),
      .go_i      (wl_go),
      .rd_en_o   (wl_rd_en),
      .rd_addr_o (wl_addr),
      .load_o    (wl_load),
      .row_o     (wl_row),
      .done_o    (wl_done)
   );

   // cfg_reuse_w only steers the IDLE exit, so it is consumed at acceptance
   // rather than stored.
   always_comb begin
      state_d   = state_q;
      num_vec_d = num_vec_q;
      vec_cnt_d = vec_cnt_q;
      drain_d   = drain_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               num_vec_d = cfg_num_vec;
               vec_cnt_d = '0;
               drain_d   = '0;
               state_d   = cfg_reuse_w ? S_CLEAR : S_WLOAD;
            end
         end
         S_WLOAD: begin
            if (wl_done) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            state_d = (num_vec_q != '0) ? S_STREAM : S_DONE;
         end
         S_STREAM: begin
            // Equality against num_vec-1 keeps the count inside CNT_W bits
            // even for the all-ones vector count.
            if (act_fire) begin
               if (vec_cnt_q == num_vec_q - CNT_W'(1)) begin
                  vec_cnt_d = '0;
                  state_d   = S_DRAIN;
               end else begin
                  vec_cnt_d = vec_cnt_q + CNT_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == DW'(DRAIN_CYC - 1)) begin
               drain_d = '0;
               state_d = S_DONE;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         S_DONE: begin
            if (bus.res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         num_vec_q <= '0;
         vec_cnt_q <= '0;
         drain_q   <= '0;
      end else begin
         state_q   <= state_d;
         num_vec_q <= num_vec_d;
         vec_cnt_q <= vec_cnt_d;
         drain_q   <= drain_d;
      end
   end

   // All outputs decode from registered state, so a reset drops every
   // strobe in the following cycle.
   assign busy                 = (state_q != S_IDLE);
   assign dbg_state            = state_q;
   assign bus.wbuf_rd_en       = wl_rd_en;
   assign bus.wbuf_rd_addr     = wl_addr;
   assign bus.sa_load_weight   = wl_load;
   assign bus.sa_load_row      = wl_row;
   assign bus.sa_weight_vector = bus.wbuf_rd_data;
   assign bus.act_ready        = (state_q == S_STREAM);
   assign bus.sa_en            = act_fire || (state_q == S_DRAIN);
   assign bus.sa_clear_acc     = (state_q == S_CLEAR);
   assign bus.sa_act_vector    = act_fire ? bus.act_data : '0;
   assign bus.res_valid        = (state_q == S_DONE);

`ifdef SYSCTRL_PERF_CNT_EN
   logic [31:0] perf_busy_q, perf_stall_q;

   always_ff @(posedge clk) begin
      if (rst || perf_clr) begin
         perf_busy_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         if (busy && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
         if ((state_q == S_STREAM) && !bus.act_valid && (perf_stall_q != '1))
            perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_busy_cyc  = perf_busy_q;
   assign perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
module tb_systolic_seq_ctrl;
   import systolic_pkg::*;

   localparam int N      = 4;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;
   localparam int DRAIN  = 2 * N;
   localparam int AW     = 2;
   localparam int VW     = N * DATA_W;
   localparam int BUDGET = 200;

   logic             clk;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] cfg_num_vec;
   logic             cfg_reuse_w;
   logic             busy;
   logic [2:0]       dbg_state;
`ifdef SYSCTRL_PERF_CNT_EN
   logic             perf_clr;
   logic [31:0]      perf_busy_cyc;
   logic [31:0]      perf_stall_cyc;
`endif

   systolic_seq_ctrl_if #(.N(N), .DATA_W(DATA_W)) bus ();

   systolic_seq_ctrl #(
      .N      (N),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .cfg_num_vec (cfg_num_vec),
      .cfg_reuse_w (cfg_reuse_w),
      .busy        (busy),
      .dbg_state   (dbg_state),
      .bus         (bus)
`ifdef SYSCTRL_PERF_CNT_EN
      ,
      .perf_clr       (perf_clr),
      .perf_busy_cyc  (perf_busy_cyc),
      .perf_stall_cyc (perf_stall_cyc)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters and logs ----------------
   int n_cmp = 0;
   int n_fail = 0;

   logic [15:0] rd_c[$], rd_a[$], ld_c[$], ld_r[$], clr_c[$], en_c[$];
   int          valid_h[$];
   int          res_c, acc_c, res_n, res_ep;
   int          w_err, a_err, ovl_err, hold_err, after_err, post_busy, timeout;
   logic [10:0] abort_out;
   logic [2:0]  abort_state;
   logic [VW-1:0] wmem [N];

   // scoreboard: expected sa_en cycles of a tile
   logic [15:0] exp_q[$];
   int          exp_clr, exp_res, exp_stall;

   // ---------------- driver / recorder ----------------
   // Cycle 0 is the cycle in which start is presented in IDLE.
   task automatic run_tile(input int nv, input bit reuse, input int vmode,
                           input int rdly, input int rst_at, input int start2_at);
      bit            prev_rd, v, fin, prev_res;
      logic [AW-1:0] prev_addr;
      rd_c.delete(); rd_a.delete(); ld_c.delete(); ld_r.delete();
      clr_c.delete(); en_c.delete(); valid_h.delete();
      res_c = -1; acc_c = -1; res_n = 0; res_ep = 0;
      w_err = 0; a_err = 0; ovl_err = 0; hold_err = 0; after_err = 0;
      post_busy = -1; timeout = 0; abort_out = '1; abort_state = '1;
      for (int i = 0; i < N; i++) wmem[i] = $urandom;
      prev_rd = 0; prev_addr = '0; fin = 0; prev_res = 0;
      cfg_num_vec = CNT_W'(nv);
      cfg_reuse_w = reuse;
      for (int c = 0; c < BUDGET && !fin; c++) begin
         @(negedge clk);
         start = (c == 0) || (c == start2_at);
         rst   = (c == rst_at);
         if (vmode == 0)      v = 1'b1;
         else if (vmode == 1) v = (c % 2 == 1);
         else                 v = ($urandom_range(0, 3) != 0);
         if (rst_at >= 0 && c >= rst_at) v = 1'b0;
         valid_h.push_back(int'(v));
         bus.act_valid    = v;
         bus.act_data     = $urandom;
         bus.wbuf_rd_data = prev_rd ? wmem[prev_addr] : $urandom;
         bus.res_ready    = 1'b0;
         #1;
         if (rst_at >= 0 && c == rst_at + 1) begin
            abort_out = {busy, bus.wbuf_rd_en, bus.wbuf_rd_addr, bus.act_ready, bus.sa_en,
                         bus.sa_clear_acc, bus.sa_load_weight, bus.sa_load_row, bus.res_valid};
            abort_state = dbg_state;
            fin = 1;
         end else begin
            if (bus.wbuf_rd_en) begin
               rd_c.push_back(16'(c)); rd_a.push_back(16'(bus.wbuf_rd_addr));
            end
            if (bus.sa_load_weight) begin
               ld_c.push_back(16'(c)); ld_r.push_back(16'(bus.sa_load_row));
               if (bus.sa_weight_vector !== wmem[bus.sa_load_row]) w_err++;
            end
            if (bus.sa_clear_acc) clr_c.push_back(16'(c));
            if (bus.sa_en) en_c.push_back(16'(c));
            if (bus.sa_act_vector !== ((v && bus.act_ready) ? bus.act_data : '0)) a_err++;
            if (int'(bus.sa_load_weight) + int'(bus.sa_clear_acc) + int'(bus.sa_en) > 1) ovl_err++;
            if (bus.res_valid && !busy) hold_err++;
            if (bus.res_valid) res_n++;
            if (bus.res_valid && !prev_res) res_ep++;
            prev_res = bus.res_valid;
            if (bus.res_valid && res_c < 0) res_c = c;
            if (bus.res_valid && (c - res_c) >= rdly) begin
               bus.res_ready = 1'b1;
               acc_c = c;
               fin = 1;
            end
            prev_rd   = bus.wbuf_rd_en;
            prev_addr = bus.wbuf_rd_addr;
         end
      end
      if (!fin) timeout = 1;
      if (acc_c >= 0) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0; bus.res_ready = 1'b0; bus.act_valid = 1'b0;
            #1;
            if (k == 0) post_busy = int'(busy);
            if (busy || bus.res_valid) after_err++;
         end
      end
      start = 1'b0; rst = 1'b0; bus.act_valid = 1'b0; bus.res_ready = 1'b0;
   endtask

   // ---------------- reference model ----------------
   // Timeline from the tile rules: clear right after start (reuse) or after
   // the N+1 cycle weight load; one en per accepted vector; DRAIN en cycles
   // after the last vector; result in the cycle after that.
   task automatic model_tile(input int nv, input bit reuse);
      int c, k;
      exp_q.delete();
      exp_stall = 0;
      exp_clr = reuse ? 1 : N + 2;
      if (nv == 0) begin
         exp_res = exp_clr + 1;
      end else begin
         c = exp_clr + 1;
         k = 0;
         while (k < nv && c < valid_h.size()) begin
            if (valid_h[c] != 0) begin
               exp_q.push_back(16'(c));
               k++;
            end else begin
               exp_stall++;
            end
            c++;
         end
         for (int d = 0; d < DRAIN; d++) exp_q.push_back(16'(c + d));
         exp_res = c + DRAIN;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if ({busy, bus.wbuf_rd_en, bus.wbuf_rd_addr, bus.act_ready, bus.sa_en, bus.sa_clear_acc,
           bus.sa_load_weight, bus.sa_load_row, bus.res_valid} !== 11'd0) begin
         n_fail++; $display("FAIL reset_outputs: got state %0d busy %0b res_valid %0b expected all 0",
                            dbg_state, busy, bus.res_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (dbg_state !== 3'(IDLE) || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle: got state %0d busy %0b expected state 0 busy 0", dbg_state, busy);
      end
`ifdef SYSCTRL_PERF_CNT_EN
      n_cmp++;
      if (perf_busy_cyc !== 32'd0 || perf_stall_cyc !== 32'd0) begin
         n_fail++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_busy_cyc, perf_stall_cyc);
      end
`endif
   endtask

   task automatic test_basic();
      run_tile(3, 0, 0, 0, -1, -1);
      model_tile(3, 0);
      n_cmp++;
      if (timeout != 0) begin n_fail++; $display("FAIL basic_timeout: got timeout expected completion"); end
      n_cmp++;
      if (rd_c.size() != N || ld_c.size() != N) begin
         n_fail++; $display("FAIL basic_wload_count: got rd %0d ld %0d expected %0d", rd_c.size(), ld_c.size(), N);
      end
      for (int k = 0; k < N && k < rd_c.size() && k < ld_c.size(); k++) begin
         n_cmp++;
         if (rd_c[k] !== 16'(k + 1) || rd_a[k] !== 16'(k) || ld_c[k] !== 16'(k + 2) || ld_r[k] !== 16'(k)) begin
            n_fail++; $display("FAIL basic_wload_row%0d: got rd@%0d addr %0d ld@%0d row %0d expected rd@%0d ld@%0d row %0d",
                               k, rd_c[k], rd_a[k], ld_c[k], ld_r[k], k + 1, k + 2, k);
         end
      end
      n_cmp++;
      if (clr_c.size() != 1 || clr_c[0] !== 16'(exp_clr)) begin
         n_fail++; $display("FAIL basic_clear: got %0d pulses expected 1 at cycle %0d", clr_c.size(), exp_clr);
      end
      n_cmp++;
      if (en_c.size() != exp_q.size()) begin
         n_fail++; $display("FAIL basic_en_count: got %0d expected %0d", en_c.size(), exp_q.size());
      end else begin
         foreach (exp_q[k]) begin
            n_cmp++;
            if (en_c[k] !== exp_q[k]) begin
               n_fail++; $display("FAIL basic_en_cycle: got %0d expected %0d", en_c[k], exp_q[k]);
            end
         end
      end
      n_cmp++;
      if (res_c != 18) begin n_fail++; $display("FAIL basic_latency: got %0d expected 18", res_c); end
      n_cmp++;
      if (w_err != 0 || a_err != 0 || ovl_err != 0) begin
         n_fail++; $display("FAIL basic_data: got weight_err %0d act_err %0d overlap %0d expected 0", w_err, a_err, ovl_err);
      end
      n_cmp++;
      if (post_busy != 0 || after_err != 0) begin
         n_fail++; $display("FAIL basic_release: got busy %0d after_err %0d expected 0", post_busy, after_err);
      end
   endtask

   task automatic test_bubbles();
`ifdef SYSCTRL_PERF_CNT_EN
      @(negedge clk); perf_clr = 1'b1;
      @(negedge clk); perf_clr = 1'b0;
`endif
      run_tile(3, 0, 1, 0, -1, -1);
      model_tile(3, 0);
      n_cmp++;
      if (en_c.size() != exp_q.size()) begin
         n_fail++; $display("FAIL bubbles_en_count: got %0d expected %0d", en_c.size(), exp_q.size());
      end else begin
         foreach (exp_q[k]) begin
            n_cmp++;
            if (en_c[k] !== exp_q[k]) begin
               n_fail++; $display("FAIL bubbles_en_cycle: got %0d expected %0d", en_c[k], exp_q[k]);
            end
         end
      end
      n_cmp++;
      if (res_c != 20 || res_c != exp_res) begin
         n_fail++; $display("FAIL bubbles_latency: got %0d expected 20 (model %0d)", res_c, exp_res);
      end
      n_cmp++;
      if (a_err != 0 || ovl_err != 0) begin
         n_fail++; $display("FAIL bubbles_act_gate: got act_err %0d overlap %0d expected 0", a_err, ovl_err);
      end
`ifdef SYSCTRL_PERF_CNT_EN
      n_cmp++;
      if (perf_stall_cyc !== 32'(exp_stall)) begin
         n_fail++; $display("FAIL perf_stall: got %0d expected %0d", perf_stall_cyc, exp_stall);
      end
      n_cmp++;
      if (perf_busy_cyc !== 32'(acc_c)) begin
         n_fail++; $display("FAIL perf_busy: got %0d expected %0d", perf_busy_cyc, acc_c);
      end
`endif
   endtask

   task automatic test_reuse();
      run_tile(1, 1, 0, 0, -1, -1);
      model_tile(1, 1);
      n_cmp++;
      if (rd_c.size() != 0 || ld_c.size() != 0) begin
         n_fail++; $display("FAIL reuse_no_wload: got rd %0d ld %0d expected 0 0", rd_c.size(), ld_c.size());
      end
      n_cmp++;
      if (clr_c.size() != 1 || clr_c[0] !== 16'd1) begin
         n_fail++; $display("FAIL reuse_clear: got %0d pulses expected 1 at cycle 1", clr_c.size());
      end
      n_cmp++;
      if (en_c.size() != exp_q.size() || en_c.size() != 1 + DRAIN) begin
         n_fail++; $display("FAIL reuse_en_count: got %0d expected %0d", en_c.size(), 1 + DRAIN);
      end
      n_cmp++;
      if (res_c != 11) begin n_fail++; $display("FAIL reuse_latency: got %0d expected 11", res_c); end
   endtask

   task automatic test_zero_vec();
      run_tile(0, 0, 0, 5, -1, -1);
      model_tile(0, 0);
      n_cmp++;
      if (en_c.size() != 0) begin n_fail++; $display("FAIL zero_no_en: got %0d en cycles expected 0", en_c.size()); end
      n_cmp++;
      if (clr_c.size() != 1 || res_c != exp_res) begin
         n_fail++; $display("FAIL zero_result: got clears %0d res at %0d expected 1 clear, res at %0d",
                            clr_c.size(), res_c, exp_res);
      end
      n_cmp++;
      if (res_n != 6 || acc_c != res_c + 5 || hold_err != 0) begin
         n_fail++; $display("FAIL zero_hold: got res cycles %0d accept %0d hold_err %0d expected 6, %0d, 0",
                            res_n, acc_c, hold_err, res_c + 5);
      end
   endtask

   task automatic test_reset_mid();
      run_tile(3, 0, 0, 0, 9, -1);
      n_cmp++;
      if (en_c.size() != 2) begin n_fail++; $display("FAIL midrst_vectors: got %0d expected 2", en_c.size()); end
      n_cmp++;
      if (abort_out !== 11'd0 || abort_state !== 3'(IDLE)) begin
         n_fail++; $display("FAIL midrst_outputs: got outputs %0h state %0d expected 0 and 0", abort_out, abort_state);
      end
      run_tile(3, 0, 0, 0, -1, -1);
      n_cmp++;
      if (rd_c.size() != N || res_c != 18) begin
         n_fail++; $display("FAIL midrst_rerun: got rd %0d res at %0d expected %0d and 18", rd_c.size(), res_c, N);
      end
   endtask

   task automatic test_start_in_drain();
      run_tile(3, 0, 0, 2, -1, 12);
      n_cmp++;
      if (res_ep != 1 || res_c != 18 || acc_c != 20) begin
         n_fail++; $display("FAIL drain_start_episode: got episodes %0d res %0d accept %0d expected 1, 18, 20",
                            res_ep, res_c, acc_c);
      end
      n_cmp++;
      if (post_busy != 0 || after_err != 0) begin
         n_fail++; $display("FAIL drain_start_idle: got busy %0d after_err %0d expected 0", post_busy, after_err);
      end
   endtask

   task automatic test_max_count();
      int nv;
      nv = (1 << CNT_W) - 1;
      run_tile(nv, 1, 0, 0, -1, -1);
      model_tile(nv, 1);
      n_cmp++;
      if (en_c.size() != nv + DRAIN || en_c.size() != exp_q.size()) begin
         n_fail++; $display("FAIL maxcnt_en_count: got %0d expected %0d", en_c.size(), nv + DRAIN);
      end
      n_cmp++;
      if (res_c != 2 + nv + DRAIN || timeout != 0) begin
         n_fail++; $display("FAIL maxcnt_latency: got %0d expected %0d", res_c, 2 + nv + DRAIN);
      end
   endtask

   task automatic test_random();
      int nv, rdly;
      bit reuse;
      for (int it = 0; it < 5; it++) begin
         nv    = $urandom_range(1, 6);
         reuse = 1'($urandom_range(0, 1));
         rdly  = $urandom_range(0, 3);
         run_tile(nv, reuse, 2, rdly, -1, -1);
         model_tile(nv, reuse);
         n_cmp++;
         if (rd_c.size() != (reuse ? 0 : N) || clr_c.size() != 1 || clr_c[0] !== 16'(exp_clr)) begin
            n_fail++; $display("FAIL rand%0d_setup: got rd %0d clears %0d expected rd %0d, 1 clear at %0d",
                               it, rd_c.size(), clr_c.size(), reuse ? 0 : N, exp_clr);
         end
         n_cmp++;
         if (en_c.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand%0d_en_count: got %0d expected %0d", it, en_c.size(), exp_q.size());
         end else begin
            foreach (exp_q[k]) begin
               n_cmp++;
               if (en_c[k] !== exp_q[k]) begin
                  n_fail++; $display("FAIL rand%0d_en_cycle: got %0d expected %0d", it, en_c[k], exp_q[k]);
               end
            end
         end
         n_cmp++;
         if (res_c != exp_res || acc_c != exp_res + rdly) begin
            n_fail++; $display("FAIL rand%0d_result: got res %0d accept %0d expected %0d, %0d",
                               it, res_c, acc_c, exp_res, exp_res + rdly);
         end
         n_cmp++;
         if (w_err != 0 || a_err != 0 || ovl_err != 0 || hold_err != 0 || after_err != 0) begin
            n_fail++; $display("FAIL rand%0d_integrity: got w %0d a %0d ovl %0d hold %0d after %0d expected 0",
                               it, w_err, a_err, ovl_err, hold_err, after_err);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1; start = 1'b0; cfg_num_vec = '0; cfg_reuse_w = 1'b0;
      bus.act_valid = 1'b0; bus.act_data = '0; bus.wbuf_rd_data = '0; bus.res_ready = 1'b0;
`ifdef SYSCTRL_PERF_CNT_EN
      perf_clr = 1'b0;
`endif
      test_reset();
      test_basic();
      test_bubbles();
      test_reuse();
      test_zero_vec();
      test_reset_mid();
      test_start_in_drain();
      test_max_count();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
